ahb_reg_slave: RTL and testbench

AHB_REG_SLAVE -- requirements
Module: ahb_reg_slave

---
 rtl/ahb_reg_slave.sv | 206 ++++++++++++++++++++
 tb/tb_ahb_reg_slave.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_reg_slave.sv
// ahb_reg_slave: AHB-Lite subordinate that turns single AHB transfers into a
// simple valid/ready register request and a single-cycle response.
// Build option: define AHB_REG_SLAVE_TIMEOUT_EN to abort a WAIT that sees no
// backend response within 255 cycles (ERROR response to the bus).
// Sizes above a word and misaligned transfers are answered with a two-cycle
// ERROR and never reach the backend.

module ahb_reg_slave (
    input  logic        clock,
    input  logic        reset,
    input  logic        auto_in_hready,
    output logic        auto_in_hreadyout,
    input  logic [1:0]  auto_in_htrans,
    input  logic [2:0]  auto_in_hsize,
    input  logic        auto_in_hwrite,
    input  logic [30:0] auto_in_haddr,
    input  logic [31:0] auto_in_hwdata,
    output logic        auto_in_hresp,
    output logic [31:0] auto_in_hrdata,
    output logic        reg_req_valid,
    input  logic        reg_req_ready,
    output logic        reg_req_write,
    output logic [30:0] reg_req_addr,
    output logic [31:0] reg_req_wdata,
    output logic [3:0]  reg_req_mask,
    input  logic        reg_resp_valid,
    input  logic [31:0] reg_resp_rdata,
    input  logic        reg_resp_error
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR1 = 3'd4,
        ST_ERR2 = 3'd5
    } state_t;

    // Size/alignment legality of an AHB transfer: byte anywhere, halfword on
    // even addresses, word on word boundaries, nothing wider.
    function automatic logic xfer_legal_f(input logic [2:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (lo[0] == 1'b0);
            3'd2:    ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-enable pattern for a (legal) transfer; reads use the same lanes.
    function automatic logic [3:0] byte_mask_f(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << lo;
            3'd1:    m = 4'b0011 << {lo[1], 1'b0};
            3'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic        capture_s;
    logic        legal_s;
    logic        timeout_s;
    logic        hreadyout_r;
    logic        hresp_r;
    logic [31:0] hrdata_r;
    logic        req_valid_r;
    logic        req_write_r;
    logic [30:0] req_addr_r;
    logic [3:0]  req_mask_r;
    logic        unused_s;

    // HTRANS[0] only separates NONSEQ/SEQ and IDLE/BUSY, which are treated alike.
    assign unused_s = auto_in_htrans[0];

    // An address phase is ours only when the bus is ready, we are ready, and the
    // transfer is NONSEQ or SEQ.
    assign capture_s = auto_in_hready & hreadyout_r & auto_in_htrans[1];
    assign legal_s   = xfer_legal_f(auto_in_hsize, auto_in_haddr[1:0]);

`ifdef AHB_REG_SLAVE_TIMEOUT_EN
    logic [7:0] wait_cnt_r;

    // WAIT-cycle counter: held at zero outside WAIT so it starts clean on every
    // WAIT entry, counts one per WAIT cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_r <= 8'd0;
        end else if (state_r != ST_WAIT) begin
            wait_cnt_r <= 8'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end
    end

    // The 255th silent WAIT cycle is the last one: the counter would reach 255
    // on this edge, so the transfer is abandoned instead.
    assign timeout_s = (state_r == ST_WAIT) && (wait_cnt_r == 8'd254);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic of the transfer FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (capture_s) begin
                    if (legal_s) begin
                        next_state_s = ST_REQ;
                    end else begin
                        next_state_s = ST_ERR1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (reg_req_ready) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (reg_resp_valid) begin
                    if (reg_resp_error) begin
                        next_state_s = ST_ERR1;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else if (timeout_s) begin
                    next_state_s = ST_ERR1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_ERR1: begin
                next_state_s = ST_ERR2;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus bus-facing outputs, all decoded from the next state so
    // that every output comes straight from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            hrdata_r    <= 32'd0;
            req_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            hreadyout_r <= (next_state_s == ST_IDLE) || (next_state_s == ST_DONE) ||
                           (next_state_s == ST_ERR2);
            hresp_r     <= (next_state_s == ST_ERR1) || (next_state_s == ST_ERR2);
            req_valid_r <= (next_state_s == ST_REQ);
            // DONE is only reached from WAIT on a good response, so the
            // response data is valid exactly when it is loaded here.
            if ((next_state_s == ST_DONE) && !req_write_r) begin
                hrdata_r <= reg_resp_rdata;
            end else begin
                hrdata_r <= 32'd0;
            end
        end
    end

    // Address-phase capture of direction, word address and byte lanes.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_write_r <= 1'b0;
            req_addr_r  <= 31'd0;
            req_mask_r  <= 4'd0;
        end else if (capture_s) begin
            req_write_r <= auto_in_hwrite;
            req_addr_r  <= {auto_in_haddr[30:2], 2'b00};
            req_mask_r  <= byte_mask_f(auto_in_hsize, auto_in_haddr[1:0]);
        end else begin
            req_write_r <= req_write_r;
            req_addr_r  <= req_addr_r;
            req_mask_r  <= req_mask_r;
        end
    end

    assign auto_in_hreadyout = hreadyout_r;
    assign auto_in_hresp     = hresp_r;
    assign auto_in_hrdata    = hrdata_r;
    assign reg_req_valid     = req_valid_r;
    assign reg_req_write     = req_write_r;
    assign reg_req_addr      = req_addr_r;
    assign reg_req_mask      = req_mask_r;
    // Write data is only valid on the bus during the data phase, which is held
    // open (HREADYOUT low) for the whole request, so it is passed straight through.
    assign reg_req_wdata     = auto_in_hwdata;

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Scoreboard bench for ahb_reg_slave: a bus driver pushes expected responses
// and backend requests into queues from a transfer-level model; a monitor pops
// and compares them as the DUT presents request handshakes and data-phase ends.

module tb_ahb_reg_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic        hready;
    logic        hready_en;
    logic        hreadyout;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [30:0] haddr;
    logic [31:0] hwdata;
    logic        hresp;
    logic [31:0] hrdata;
    logic        reg_req_valid;
    logic        reg_req_ready;
    logic        reg_req_write;
    logic [30:0] reg_req_addr;
    logic [31:0] reg_req_wdata;
    logic [3:0]  reg_req_mask;
    logic        reg_resp_valid;
    logic [31:0] reg_resp_rdata;
    logic        reg_resp_error;

    // backend inputs are muxed between the automatic backend and manual drive
    logic        be_auto;
    logic        be_ready, be_rvalid, be_rerr;
    logic [31:0] be_rdata;
    logic        man_ready, man_rvalid;
    logic [31:0] man_rdata;

    assign reg_req_ready  = be_auto ? be_ready  : man_ready;
    assign reg_resp_valid = be_auto ? be_rvalid : man_rvalid;
    assign reg_resp_rdata = be_auto ? be_rdata  : man_rdata;
    assign reg_resp_error = be_auto ? be_rerr   : 1'b0;
    assign hready         = hreadyout & hready_en;

    always #5 clock = ~clock;

    ahb_reg_slave dut (
        .clock             (clock),
        .reset             (reset),
        .auto_in_hready    (hready),
        .auto_in_hreadyout (hreadyout),
        .auto_in_htrans    (htrans),
        .auto_in_hsize     (hsize),
        .auto_in_hwrite    (hwrite),
        .auto_in_haddr     (haddr),
        .auto_in_hwdata    (hwdata),
        .auto_in_hresp     (hresp),
        .auto_in_hrdata    (hrdata),
        .reg_req_valid     (reg_req_valid),
        .reg_req_ready     (reg_req_ready),
        .reg_req_write     (reg_req_write),
        .reg_req_addr      (reg_req_addr),
        .reg_req_wdata     (reg_req_wdata),
        .reg_req_mask      (reg_req_mask),
        .reg_resp_valid    (reg_resp_valid),
        .reg_resp_rdata    (reg_resp_rdata),
        .reg_resp_error    (reg_resp_error)
    );

    typedef struct {
        bit [1:0]  trans;
        bit [2:0]  size;
        bit        write;
        bit [30:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        bit        err;
        int        rdly;
        int        pdly;
    } xfer_t;

    typedef struct { int waits; bit resp; bit chk_rdata; bit [31:0] rdata; } exp_rsp_t;
    typedef struct { bit write; bit [30:0] addr; bit [3:0] mask; bit [31:0] wdata; } exp_req_t;
    typedef struct { bit [31:0] rdata; bit err; int rdly; int pdly; } be_cfg_t;

    exp_rsp_t exp_rsp_q[$];
    exp_req_t exp_req_q[$];
    be_cfg_t  be_q[$];
    xfer_t    xq[$];

    int n_chk = 0;
    int n_bad = 0;
    bit mon_en;
    bit drv_valid;
    bit pending_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- transfer-level reference model ----------------
    function automatic bit is_legal(input bit [2:0] size, input bit [30:0] addr);
        int a;
        a = int'(addr % 31'd4);
        if (size == 3'd0) return 1'b1;
        if (size == 3'd1) return (a % 2) == 0;
        if (size == 3'd2) return a == 0;
        return 1'b0;
    endfunction

    function automatic bit [3:0] mask_of(input bit [2:0] size, input bit [30:0] addr);
        int a;
        a = int'(addr % 31'd4);
        if (size == 3'd0) return 4'(1 << a);
        if (size == 3'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic xfer_t mk(input bit [1:0] t, input bit [2:0] s, input bit w,
                                 input bit [30:0] a, input bit [31:0] wd, input bit [31:0] rd,
                                 input bit e, input int rd_dly, input int rsp_dly);
        xfer_t x;
        x.trans = t; x.size = s; x.write = w; x.addr = a; x.wdata = wd;
        x.rdata = rd; x.err = e; x.rdly = rd_dly; x.pdly = rsp_dly;
        return x;
    endfunction

    // Present one address phase, wait for acceptance, record expectations,
    // then start its data phase.
    task automatic issue(input xfer_t x);
        exp_rsp_t e;
        exp_req_t r;
        be_cfg_t  c;
        int       guard;
        htrans = x.trans; hsize = x.size; hwrite = x.write; haddr = x.addr;
        drv_valid = 1'b1;
        if (pending_hold) begin
            hready_en = 1'b0;
            @(negedge clock);
            hready_en = 1'b1;
            pending_hold = 1'b0;
        end
        #1;
        guard = 0;
        while (!hready && guard < 2000) begin
            @(negedge clock); #1;
            guard++;
        end
        if (!hready) begin
            $display("FAIL accept_timeout: got hready=0, expected 1 within 2000 cycles");
            $fatal(1, "driver stuck");
        end
        if (x.trans >= 2'd2 && is_legal(x.size, x.addr)) begin
            r.write = x.write;
            r.addr  = x.addr - 31'(x.addr % 31'd4);
            r.mask  = mask_of(x.size, x.addr);
            r.wdata = x.wdata;
            exp_req_q.push_back(r);
            c.rdata = x.rdata; c.err = x.err; c.rdly = x.rdly; c.pdly = x.pdly;
            be_q.push_back(c);
            e.waits     = x.rdly + x.pdly + (x.err ? 3 : 2);
            e.resp      = x.err;
            e.chk_rdata = !x.write || x.err;
            e.rdata     = (x.write || x.err) ? 32'd0 : x.rdata;
        end else if (x.trans >= 2'd2) begin
            e.waits = 1; e.resp = 1'b1; e.chk_rdata = 1'b1; e.rdata = 32'd0;
        end else begin
            pending_hold = ($urandom_range(0, 2) == 0);
            e.waits = pending_hold ? 1 : 0;
            e.resp = 1'b0; e.chk_rdata = 1'b1; e.rdata = 32'd0;
        end
        exp_rsp_q.push_back(e);
        @(negedge clock);
        hwdata = x.wdata;
        drv_valid = 1'b0;
        htrans = 2'b00;
    endtask

    // ---------------- backend responder ----------------
    initial begin : backend
        be_cfg_t c;
        be_ready = 1'b0; be_rvalid = 1'b0; be_rerr = 1'b0; be_rdata = 32'd0;
        forever begin
            @(negedge clock);
            be_rvalid = 1'b0; be_rerr = 1'b0;
            if (be_auto && reg_req_valid) begin
                if (be_q.size() == 0) begin
                    n_chk++; n_bad++;
                    $display("FAIL be_unexpected: got request addr 0x%0h, expected none", reg_req_addr);
                    c.rdata = 32'd0; c.err = 1'b0; c.rdly = 0; c.pdly = 0;
                end else begin
                    c = be_q.pop_front();
                end
                repeat (c.rdly) @(negedge clock);
                be_ready = 1'b1;
                @(negedge clock);
                be_ready = 1'b0;
                repeat (c.pdly) @(negedge clock);
                be_rvalid = 1'b1; be_rdata = c.rdata; be_rerr = c.err;
                @(negedge clock);
                be_rvalid = 1'b0; be_rerr = 1'b0; be_rdata = $urandom;
            end else if (be_auto && $urandom_range(0, 7) == 0) begin
                // stray response outside WAIT: must be ignored
                be_rvalid = 1'b1; be_rerr = 1'($urandom_range(0, 1)); be_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit       pending;
        bit       prev_hresp;
        int       waits;
        exp_rsp_t e;
        exp_req_t r;
        pending = 1'b0; prev_hresp = 1'b0; waits = 0;
        forever begin
            @(negedge clock); #1;
            if (mon_en) begin
                if (reg_req_valid && reg_req_ready) begin
                    if (exp_req_q.size() == 0) begin
                        n_chk++; n_bad++;
                        $display("FAIL req_unexpected: got request addr 0x%0h, expected none", reg_req_addr);
                    end else begin
                        r = exp_req_q.pop_front();
                        chk("req_write", 32'(reg_req_write), 32'(r.write));
                        chk("req_addr",  32'(reg_req_addr),  32'(r.addr));
                        chk("req_mask",  32'(reg_req_mask),  32'(r.mask));
                        chk("req_wdata", reg_req_wdata, r.wdata);
                    end
                end
                if (pending && hready) begin
                    if (exp_rsp_q.size() == 0) begin
                        n_chk++; n_bad++;
                        $display("FAIL rsp_unexpected: got completion, expected none");
                    end else begin
                        e = exp_rsp_q.pop_front();
                        chk("wait_cycles", 32'(waits), 32'(e.waits));
                        chk("hresp", 32'(hresp), 32'(e.resp));
                        if (e.chk_rdata) chk("hrdata", hrdata, e.rdata);
                        if (e.resp) chk("err_first_cycle", 32'(prev_hresp), 32'd1);
                    end
                    waits = 0;
                end else if (pending) begin
                    waits++;
                    chk("hrdata_zero", hrdata, 32'd0);
                end
                if (hready) pending = drv_valid;
                prev_hresp = hresp;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin : main
        int   g;
        int   n;
        bit [1:0] t;
        bit [2:0] s;
        reset = 1'b1; hready_en = 1'b1; htrans = 2'b00; hsize = 3'd0; hwrite = 1'b0;
        haddr = 31'd0; hwdata = 32'd0; be_auto = 1'b1; man_ready = 1'b0;
        man_rvalid = 1'b0; man_rdata = 32'd0; mon_en = 1'b1; drv_valid = 1'b0;
        pending_hold = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_req_valid", 32'(reg_req_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // directed transfers
        xq.push_back(mk(2'b10, 3'd2, 1'b1, 31'h100, 32'hDEADBEEF, 32'd0, 1'b0, 0, 0));
        xq.push_back(mk(2'b00, 3'd0, 1'b0, 31'h0,   32'd0, 32'd0, 1'b0, 0, 0));
        xq.push_back(mk(2'b10, 3'd0, 1'b0, 31'h103, 32'd0, 32'h11223344, 1'b0, 0, 0));
        xq.push_back(mk(2'b00, 3'd0, 1'b0, 31'h0,   32'd0, 32'd0, 1'b0, 0, 0));
        xq.push_back(mk(2'b10, 3'd1, 1'b1, 31'h101, 32'h55AA55AA, 32'd0, 1'b0, 0, 0));
        xq.push_back(mk(2'b00, 3'd0, 1'b0, 31'h0,   32'd0, 32'd0, 1'b0, 0, 0));
        xq.push_back(mk(2'b10, 3'd2, 1'b1, 31'h104, 32'h01234567, 32'd0, 1'b0, 0, 0));
        xq.push_back(mk(2'b10, 3'd2, 1'b0, 31'h108, 32'd0, 32'hA5A5F00F, 1'b0, 0, 0));
        xq.push_back(mk(2'b00, 3'd0, 1'b0, 31'h0,   32'd0, 32'd0, 1'b0, 0, 0));
        xq.push_back(mk(2'b11, 3'd2, 1'b0, 31'h10C, 32'd0, 32'h0BADC0DE, 1'b1, 1, 2));

        // randomized transfers
        for (int i = 0; i < 150; i++) begin
            n = $urandom_range(0, 9);
            t = (n < 2) ? 2'b00 : (n == 2) ? 2'b01 : 2'(2 + $urandom_range(0, 1));
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            xq.push_back(mk(t, s, 1'($urandom_range(0, 1)), 31'($urandom), $urandom, $urandom,
                            ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3)));
        end

        foreach (xq[i]) issue(xq[i]);
        if (pending_hold) begin
            hready_en = 1'b0;
            @(negedge clock);
            hready_en = 1'b1;
            pending_hold = 1'b0;
        end

        g = 0;
        while ((exp_rsp_q.size() != 0 || exp_req_q.size() != 0) && g < 1000) begin
            @(negedge clock);
            g++;
        end
        repeat (2) @(negedge clock);
        chk("rsp_q_drained", 32'(exp_rsp_q.size()), 32'd0);
        chk("req_q_drained", 32'(exp_req_q.size()), 32'd0);
        chk("be_q_drained", 32'(be_q.size()), 32'd0);

        // reset while waiting for the backend, then a late response
        mon_en = 1'b0; be_auto = 1'b0;
        @(negedge clock);
        htrans = 2'b10; haddr = 31'h200; hsize = 3'd2; hwrite = 1'b0;
        #1;
        chk("rst_setup_ready", 32'(hready), 32'd1);
        @(negedge clock);
        htrans = 2'b00;
        #1;
        chk("rst_req_issued", 32'(reg_req_valid), 32'd1);
        man_ready = 1'b1;
        @(negedge clock);
        man_ready = 1'b0;
        #1;
        chk("rst_in_wait", 32'(hreadyout), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        man_rvalid = 1'b1; man_rdata = 32'hCAFEF00D;
        #1;
        chk("rst_mid_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_mid_req_valid", 32'(reg_req_valid), 32'd0);
        @(negedge clock);
        man_rvalid = 1'b0;
        #1;
        chk("rst_resp_ignored_hrdata", hrdata, 32'd0);
        chk("rst_resp_ignored_hready", 32'(hreadyout), 32'd1);
        chk("rst_resp_ignored_hresp", 32'(hresp), 32'd0);

`ifdef AHB_REG_SLAVE_TIMEOUT_EN
        // no backend response: abort after 255 WAIT cycles
        @(negedge clock);
        htrans = 2'b10; haddr = 31'h10; hsize = 3'd2; hwrite = 1'b1;
        @(negedge clock);
        htrans = 2'b00; man_ready = 1'b1;
        @(negedge clock);
        man_ready = 1'b0;
        #1;
        n = 0;
        while (hresp == 1'b0 && hreadyout == 1'b0 && n < 400) begin
            n++;
            @(negedge clock); #1;
        end
        chk("timeout_wait_cycles", 32'(n), 32'd255);
        chk("timeout_err1_hresp", 32'(hresp), 32'd1);
        chk("timeout_err1_hready", 32'(hreadyout), 32'd0);
        @(negedge clock); #1;
        chk("timeout_err2_hresp", 32'(hresp), 32'd1);
        chk("timeout_err2_hready", 32'(hreadyout), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
